// File: rtl/sequenciador_multiciclo_if.sv
// Bus between the multicycle control sequencer and the datapath blocks it steers.
// SEQ_SINGLE_STEP_EN adds the step request line.
interface sequenciador_multiciclo_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      instrucao;
    logic             mem_ready;
    logic             start;
`ifdef SEQ_SINGLE_STEP_EN
    logic             step;
`endif
    logic [3:0]       estado;
    logic             mem_req;
    logic             reg_we_en;
    logic             pc_en;
    logic             final_flag;
    logic             busy;
    logic [CNT_W-1:0] instr_count;

`ifdef SEQ_SINGLE_STEP_EN
    modport master (
        input  instrucao, mem_ready, start, step,
        output estado, mem_req, reg_we_en, pc_en, final_flag, busy, instr_count
    );
    modport slave (
        output instrucao, mem_ready, start, step,
        input  estado, mem_req, reg_we_en, pc_en, final_flag, busy, instr_count
    );
`else
    modport master (
        input  instrucao, mem_ready, start,
        output estado, mem_req, reg_we_en, pc_en, final_flag, busy, instr_count
    );
    modport slave (
        output instrucao, mem_ready, start,
        input  estado, mem_req, reg_we_en, pc_en, final_flag, busy, instr_count
    );
`endif
endinterface

// File: rtl/sequenciador_multiciclo.sv
// Phase sequencer for the multicycle RISC-V datapath with programmable wait states,
// memory ready handshake, halt/restart and a saturating retired-instruction counter.
// Optional feature macro: SEQ_SINGLE_STEP_EN (SUMPC waits for the step request).
module sequenciador_multiciclo #(
    parameter int          EX_WAIT    = 2,
    parameter int          WB_WAIT    = 2,
    parameter logic [31:0] HALT_INSTR = 32'h0000_0000,
    parameter int          CNT_W      = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    sequenciador_multiciclo_if.master  bus
);

    typedef enum logic [3:0] {
        S_IF      = 4'b0000,
        S_ID      = 4'b0001,
        S_EX      = 4'b0010,
        S_MEM     = 4'b0011,
        S_WB      = 4'b0100,
        S_WAIT_EX = 4'b0101,
        S_WAIT_WB = 4'b0110,
        S_SUMPC   = 4'b1000,
        S_FIM     = 4'b1001
    } state_t;

    // Counter reload values are N-1 so a wait state lasts exactly N cycles.
    localparam logic [3:0]       EX_LOAD = (EX_WAIT > 0) ? 4'(EX_WAIT - 1) : 4'd0;
    localparam logic [3:0]       WB_LOAD = (WB_WAIT > 0) ? 4'(WB_WAIT - 1) : 4'd0;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_r;
    state_t           next_state_s;
    logic [3:0]       wait_r;
    logic [3:0]       wait_next_s;
    logic [CNT_W-1:0] count_r;
    logic             final_r;
    logic             mem_req_r;
    logic             reg_we_en_r;
    logic             busy_r;
    logic             advance_s;

`ifdef SEQ_SINGLE_STEP_EN
    assign advance_s = bus.step;
`else
    assign advance_s = 1'b1;
`endif

    // Next phase and wait-counter value from the current phase and handshakes.
    always_comb begin
        next_state_s = state_r;
        wait_next_s  = wait_r;
        case (state_r)
            S_IF: begin
                next_state_s = S_ID;
            end
            S_ID: begin
                if (bus.instrucao == HALT_INSTR) begin
                    next_state_s = S_FIM;
                end else begin
                    next_state_s = S_EX;
                end
            end
            S_EX: begin
                if (EX_WAIT > 0) begin
                    next_state_s = S_WAIT_EX;
                    wait_next_s  = EX_LOAD;
                end else begin
                    next_state_s = S_MEM;
                end
            end
            S_WAIT_EX: begin
                if (wait_r == 4'd0) begin
                    next_state_s = S_MEM;
                end else begin
                    wait_next_s = wait_r - 4'd1;
                end
            end
            S_MEM: begin
                if (bus.mem_ready) begin
                    next_state_s = S_WB;
                end else begin
                    next_state_s = S_MEM;
                end
            end
            S_WB: begin
                if (WB_WAIT > 0) begin
                    next_state_s = S_WAIT_WB;
                    wait_next_s  = WB_LOAD;
                end else begin
                    next_state_s = S_SUMPC;
                end
            end
            S_WAIT_WB: begin
                if (wait_r == 4'd0) begin
                    next_state_s = S_SUMPC;
                end else begin
                    wait_next_s = wait_r - 4'd1;
                end
            end
            S_SUMPC: begin
                if (advance_s) begin
                    next_state_s = S_IF;
                end else begin
                    next_state_s = S_SUMPC;
                end
            end
            S_FIM: begin
                if (bus.start) begin
                    next_state_s = S_IF;
                end else begin
                    next_state_s = S_FIM;
                end
            end
            default: begin
                next_state_s = S_IF;
                wait_next_s  = 4'd0;
            end
        endcase
    end

    // Phase register plus halt flag, counter and the registered phase decodes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= S_IF;
            wait_r      <= 4'd0;
            count_r     <= {CNT_W{1'b0}};
            final_r     <= 1'b0;
            mem_req_r   <= 1'b0;
            reg_we_en_r <= 1'b0;
            busy_r      <= 1'b1;
        end else begin
            state_r     <= next_state_s;
            wait_r      <= wait_next_s;
            mem_req_r   <= (next_state_s == S_MEM);
            reg_we_en_r <= (next_state_s == S_WB);
            busy_r      <= (next_state_s != S_FIM);
            if (state_r == S_FIM && bus.start) begin
                final_r <= 1'b0;
                count_r <= {CNT_W{1'b0}};
            end else if (state_r == S_ID && next_state_s == S_FIM) begin
                final_r <= 1'b1;
            end else if (state_r == S_SUMPC && advance_s && count_r != CNT_MAX) begin
                count_r <= count_r + CNT_ONE;
            end else begin
                final_r <= final_r;
                count_r <= count_r;
            end
        end
    end

    assign bus.estado      = state_r;
    assign bus.mem_req     = mem_req_r;
    assign bus.reg_we_en   = reg_we_en_r;
    assign bus.pc_en       = (state_r == S_SUMPC) && advance_s;
    assign bus.final_flag  = final_r;
    assign bus.busy        = busy_r;
    assign bus.instr_count = count_r;

endmodule

// File: tb/tb_sequenciador_multiciclo.sv
// Randomized bench: builds the expected per-cycle phase schedule of each instruction
// and compares every output of two differently parameterised sequencers against it.
module tb_sequenciador_multiciclo;

    localparam logic [3:0] P_IF = 4'b0000, P_ID = 4'b0001, P_EX = 4'b0010, P_MEM = 4'b0011;
    localparam logic [3:0] P_WB = 4'b0100, P_WEX = 4'b0101, P_WWB = 4'b0110;
    localparam logic [3:0] P_SUMPC = 4'b1000, P_FIM = 4'b1001;

    typedef struct {
        logic [3:0]  st;
        logic [31:0] instr;
        logic        rdy;
        logic        stp;
        logic        strt;
        logic        pc;
        logic        fin;
        logic [15:0] cnt;
    } ent_t;

    logic clk;
    logic rst_a;
    logic rst_b;
    int   n_checks;
    int   n_fail;

    ent_t        sched[$];
    logic [15:0] m_cnt;
    logic        m_fin;

    sequenciador_multiciclo_if #(.CNT_W(16)) ia ();
    sequenciador_multiciclo_if #(.CNT_W(2))  ib ();

    sequenciador_multiciclo #(.EX_WAIT(2), .WB_WAIT(2), .HALT_INSTR(32'h0000_0000), .CNT_W(16))
        dut_a (.clk(clk), .rst(rst_a), .bus(ia.master));
    sequenciador_multiciclo #(.EX_WAIT(0), .WB_WAIT(0), .HALT_INSTR(32'h0000_0000), .CNT_W(2))
        dut_b (.clk(clk), .rst(rst_b), .bus(ib.master));

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] cnt_max(input int sel);
        return (sel != 0) ? 16'd3 : 16'hFFFF;
    endfunction

    task automatic push(input logic [3:0] st, input logic [31:0] instr, input logic rdy,
                        input logic stp, input logic strt, input logic pc);
        ent_t e;
        e.st = st; e.instr = instr; e.rdy = rdy; e.stp = stp; e.strt = strt; e.pc = pc;
        e.fin = m_fin; e.cnt = m_cnt;
        sched.push_back(e);
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expected cycle-by-cycle schedule for one instruction; idle inputs are randomised.
    task automatic add_instr(input int sel, input bit halt, input int stalls,
                             input int stepdly, input int hold);
        int exw;
        exw = (sel != 0) ? 0 : 2;
        push(P_IF, $urandom, rbit(), rbit(), rbit(), 1'b0);
        push(P_ID, halt ? 32'h0000_0000 : ($urandom | 32'h1), rbit(), rbit(), rbit(), 1'b0);
        if (halt) begin
            m_fin = 1'b1;
            for (int i = 0; i < hold; i++) push(P_FIM, $urandom, rbit(), rbit(), 1'b0, 1'b0);
            push(P_FIM, $urandom, rbit(), rbit(), 1'b1, 1'b0);
            m_fin = 1'b0;
            m_cnt = 16'd0;
        end else begin
            push(P_EX, $urandom, rbit(), rbit(), rbit(), 1'b0);
            for (int i = 0; i < exw; i++) push(P_WEX, $urandom, rbit(), rbit(), rbit(), 1'b0);
            for (int i = 0; i < stalls; i++) push(P_MEM, $urandom, 1'b0, rbit(), rbit(), 1'b0);
            push(P_MEM, $urandom, 1'b1, rbit(), rbit(), 1'b0);
            push(P_WB, $urandom, rbit(), rbit(), rbit(), 1'b0);
            for (int i = 0; i < exw; i++) push(P_WWB, $urandom, rbit(), rbit(), rbit(), 1'b0);
`ifdef SEQ_SINGLE_STEP_EN
            for (int i = 0; i < stepdly; i++) push(P_SUMPC, $urandom, rbit(), 1'b0, rbit(), 1'b0);
`endif
            push(P_SUMPC, $urandom, rbit(), 1'b1, rbit(), 1'b1);
            if (m_cnt != cnt_max(sel)) m_cnt = m_cnt + 16'd1;
        end
    endtask

    task automatic drive(input int sel, input ent_t e);
        if (sel == 0) begin
            ia.instrucao = e.instr; ia.mem_ready = e.rdy; ia.start = e.strt;
`ifdef SEQ_SINGLE_STEP_EN
            ia.step = e.stp;
`endif
        end else begin
            ib.instrucao = e.instr; ib.mem_ready = e.rdy; ib.start = e.strt;
`ifdef SEQ_SINGLE_STEP_EN
            ib.step = e.stp;
`endif
        end
    endtask

    task automatic check_outputs(input int sel, input ent_t e);
        logic [3:0]  st;
        logic [15:0] cnt;
        logic        mreq, rwe, pc, fin, busy;
        if (sel == 0) begin
            st = ia.estado; cnt = ia.instr_count; mreq = ia.mem_req; rwe = ia.reg_we_en;
            pc = ia.pc_en; fin = ia.final_flag; busy = ia.busy;
        end else begin
            st = ib.estado; cnt = {14'd0, ib.instr_count}; mreq = ib.mem_req; rwe = ib.reg_we_en;
            pc = ib.pc_en; fin = ib.final_flag; busy = ib.busy;
        end
        check_val("estado", {28'd0, st}, {28'd0, e.st});
        check_val("mem_req", {31'd0, mreq}, {31'd0, (e.st == P_MEM)});
        check_val("reg_we_en", {31'd0, rwe}, {31'd0, (e.st == P_WB)});
        check_val("pc_en", {31'd0, pc}, {31'd0, e.pc});
        check_val("busy", {31'd0, busy}, {31'd0, (e.st != P_FIM)});
        check_val("final", {31'd0, fin}, {31'd0, e.fin});
        check_val("instr_count", {16'd0, cnt}, {16'd0, e.cnt});
    endtask

    // Plays the schedule; optionally stops, undriven, at the first entry in phase stop_st.
    task automatic run_sched(input int sel, input int stop_st);
        ent_t e;
        while (sched.size() > 0) begin
            e = sched[0];
            if (int'(e.st) == stop_st) return;
            drive(sel, e);
            #1;
            check_outputs(sel, e);
            void'(sched.pop_front());
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input int sel, input logic strt);
        ent_t e;
        e.st = P_IF; e.instr = $urandom; e.rdy = 1'b1; e.stp = 1'b1; e.strt = strt;
        e.pc = 1'b0; e.fin = 1'b0; e.cnt = 16'd0;
        drive(sel, e);
        if (sel == 0) rst_a = 1'b0; else rst_b = 1'b0;
        @(posedge clk);
        #1;
        e.stp = 1'b0;
        drive(sel, e);
        #1;
        check_outputs(sel, e);
        if (sel == 0) rst_a = 1'b1; else rst_b = 1'b1;
        sched.delete();
        m_cnt = 16'd0;
        m_fin = 1'b0;
    endtask

    initial begin
        clk = 1'b0; rst_a = 1'b0; rst_b = 1'b0;
        n_checks = 0; n_fail = 0; m_cnt = 16'd0; m_fin = 1'b0;
        ia.instrucao = 32'h0; ia.mem_ready = 1'b0; ia.start = 1'b0;
        ib.instrucao = 32'h0; ib.mem_ready = 1'b0; ib.start = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
        ia.step = 1'b0; ib.step = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;

        // Default parameters: nominal, stalled, random, halt/restart.
        do_reset(0, 1'b0);
        add_instr(0, 1'b0, 0, 5, 0);
        add_instr(0, 1'b0, 3, 0, 0);
        for (int i = 0; i < 6; i++) add_instr(0, 1'b0, $urandom_range(0, 3), $urandom_range(0, 3), 0);
        add_instr(0, 1'b1, 0, 0, 20);
        add_instr(0, 1'b0, 1, 1, 0);
        add_instr(0, 1'b0, 0, 0, 0);
        run_sched(0, -1);

        // Reset in the middle of WAIT_EX.
        add_instr(0, 1'b0, 0, 0, 0);
        run_sched(0, int'(P_WEX));
        do_reset(0, 1'b0);

        // Reset together with start while halted.
        add_instr(0, 1'b0, 2, 0, 0);
        add_instr(0, 1'b1, 0, 0, 3);
        run_sched(0, int'(P_FIM));
        do_reset(0, 1'b1);
        add_instr(0, 1'b0, 0, 0, 0);
        run_sched(0, -1);
        rst_a = 1'b0;

        // No wait states, 2-bit saturating counter.
        do_reset(1, 1'b0);
        for (int i = 0; i < 5; i++) add_instr(1, 1'b0, $urandom_range(0, 2), $urandom_range(0, 2), 0);
        run_sched(1, -1);
        check_val("saturated_count", {30'd0, ib.instr_count}, 32'd3);
        add_instr(1, 1'b1, 0, 0, 4);
        add_instr(1, 1'b0, 0, 0, 0);
        run_sched(1, -1);
        rst_b = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sequenciador_multiciclo.md
# sequenciador_multiciclo

Parametrised control sequencer for the multicycle RISC-V datapath. It generates the per-instruction phase sequence IF → ID → EX → MEM → WB → SUMPC and drives the shared `estado` bus consumed by the fetch, decode, register, ALU and memory blocks. It replaces fixed auxiliary delay states with programmable wait counters and adds a memory ready handshake. It also provides restart-after-halt and a retired-instruction counter.

## Interface
- `EX_WAIT`, default 2: wait cycles between EX and MEM; range 0–15.
- `WB_WAIT`, default 2: wait cycles between WB and SUMPC; range 0–15.
- `HALT_INSTR`, default 32'h0000_0000: instruction word that halts execution when decoded in ID.
- `CNT_W`, default 16: width of the retired-instruction counter.

Ports:
- `clk` input 1: single clock; all logic on the rising edge.
- `rst` input 1: synchronous, active-low reset.
- `instrucao` input 32: current instruction word, valid in ID.
- `mem_ready` input 1: memory completion, sampled in MEM.
- `start` input 1: restart request, honoured only in FIM.
- `estado` output 4: current phase.
- `mem_req` output 1: high while `estado` is MEM.
- `reg_we_en` output 1: high while `estado` is WB.
- `pc_en` output 1: one-cycle PC update strobe.
- `final` output 1: halted flag.
- `busy` output 1: high whenever `estado` is not FIM.
- `instr_count` output CNT_W: retired instructions, saturating.

## Operation
- State encodings on `estado`:
  - IF = 4'b0000, ID = 4'b0001, EX = 4'b0010, MEM = 4'b0011, WB = 4'b0100.
  - WAIT_EX = 4'b0101, WAIT_WB = 4'b0110, SUMPC = 4'b1000, FIM = 4'b1001.
  - No other codes are ever driven.
- Transitions:
  - IF → ID.
  - ID → FIM if `instrucao == HALT_INSTR`, otherwise ID → EX.
  - EX → WAIT_EX if `EX_WAIT > 0`, otherwise EX → MEM. WAIT_EX lasts exactly `EX_WAIT` cycles, then → MEM.
  - MEM → WB when `mem_ready == 1` at the edge; otherwise MEM holds (stall, no limit).
  - WB → WAIT_WB if `WB_WAIT > 0`, otherwise WB → SUMPC. WAIT_WB lasts exactly `WB_WAIT` cycles, then → SUMPC.
  - SUMPC → IF when `advance`.
  - FIM holds until `start == 1`, then → IF.
- `advance` is 1 unless SEQ_SINGLE_STEP_EN is defined (see Configuration).
- Wait counter: one shared down-counter of 4 bits. It is loaded with N−1 on entry to the wait state and exits the wait state at 0.
- `pc_en` = (estado == SUMPC) && `advance`. It is combinational from registered state and never high for more than one cycle per instruction.
- `instr_count` increments on the SUMPC → IF edge and saturates at 2^CNT_W − 1 (no wrap).
- `final`:
  - Set on the same edge that enters FIM, so it is valid in the first FIM cycle.
  - Cleared on the FIM → IF restart edge; `instr_count` is also cleared to 0 on that edge.
- `start` outside FIM is ignored.
- Reset: `rst == 0` at any edge forces `estado` = IF, `final` = 0, `instr_count` = 0, wait counter = 0. This holds in any state, mid-stall or mid-wait. Reset has priority over `start` and `step`.
- Reset values of outputs:
  - `estado` = 0000, `final` = 0, `instr_count` = 0, `busy` = 1.
  - `mem_req`, `reg_we_en` and `pc_en` = 0.

## Timing
- Cycles per instruction with no stall = 6 + EX_WAIT + WB_WAIT. With the defaults this is 10.
- Each cycle `mem_ready` is low in MEM adds exactly one cycle.
- A halt word is detected in ID; FIM is entered 2 cycles after IF. No EX/MEM/WB strobes occur for the halt word.
- Restart: `start` sampled high in FIM → `estado` = IF on that edge; the first instruction follows the normal timing.
- `mem_req` and `reg_we_en` are pure decodes of the registered state and need no extra latency.

## Configuration
- `SEQ_SINGLE_STEP_EN` defined:
  - Adds input port `step` (1 bit).
  - `advance` = `step`; SUMPC holds with `pc_en` = 0 until `step` is sampled high.
  - `instr_count` increments only on the advancing edge.
- `SEQ_SINGLE_STEP_EN` undefined: the `step` port is absent and `advance` = 1.

## Test plan
- Defaults, `instrucao` = 32'h0050_0093, `mem_ready` = 1 → `estado` sequence 0,1,2,5,5,3,4,6,6,8,0 with `pc_en` high only in the cycle-10 SUMPC; `instr_count` = 1 after the edge.
- `mem_ready` low for the first 3 MEM cycles → MEM held 4 cycles with `mem_req` = 1 throughout; instruction takes 13 cycles.
- `instrucao` = 0 in ID → next edge `estado` = 1001, `final` = 1, `busy` = 0, and these hold for 20 cycles. A one-cycle `start` pulse → IF, `final` = 0, `instr_count` = 0.
- EX_WAIT = 0, WB_WAIT = 0 → 6 cycles per instruction; codes 0101 and 0110 never appear. With CNT_W = 2, 5 instructions → `instr_count` = 3 (saturated).
- `rst` = 0 during WAIT_EX, and separately with `start` = 1 in FIM → next edge `estado` = 0000, `final` = 0, counter 0; `rst` wins over `start`.
- With `SEQ_SINGLE_STEP_EN` defined, `step` low for 5 cycles → SUMPC held with `pc_en` = 0. `step` high for 1 cycle → exactly one `pc_en` pulse, then IF.
